// File: rtl/maxpool2x2.sv
// ---------------------------------------------------------------------------
// maxpool2x2
//   2x2 / stride-2 max pooling over CH byte-wide feature maps held in a source
//   BRAM (row-major per channel, channel-major overall, 4 pixels per word,
//   pixel 0 in [31:24]). Each output word packs 4 pooled pixels and is built
//   from four source words A,B (top row pair) and C,D (bottom row pair).
//   A run takes exactly 6 cycles per output word: RD0..RD3, LAST, WR.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-low
//   start     in   1-cycle pulse, accepted in IDLE or DONE
//   finish    out  high from end of run until the cycle after an accepted start
//   S_R_req   out  source read request (RD0..RD3)
//   S_addr    out  source word address
//   S_R_data  in   source read data, valid the cycle after S_R_req
//   S_W_req   out  source byte write enables, always 0
//   S_W_data  out  source write data, always 0
//   D_R_req   out  destination read request, always 0
//   D_addr    out  destination word address
//   D_R_data  in   destination read data, unused
//   D_W_req   out  destination byte write enables, 4'b1111 in WR
//   D_W_data  out  destination write data (pooled word)
// ---------------------------------------------------------------------------
module maxpool2x2 #(
  parameter int IMG_W    = 24,
  parameter int IMG_H    = 24,
  parameter int CH       = 4,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0,
  parameter int SIGNED   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        S_R_req,
  output logic [31:0] S_addr,
  input  logic [31:0] S_R_data,
  output logic [3:0]  S_W_req,
  output logic [31:0] S_W_data,
  output logic        D_R_req,
  output logic [31:0] D_addr,
  input  logic [31:0] D_R_data,
  output logic [3:0]  D_W_req,
  output logic [31:0] D_W_data
);

  localparam int WPR = IMG_W / 4;
  localparam int OW  = IMG_W / 8;
  localparam int OH  = IMG_H / 2;

  localparam logic [15:0] COL_LAST = 16'(OW - 1);
  localparam logic [15:0] ROW_LAST = 16'(OH - 1);
  localparam logic [15:0] CH_LAST  = 16'(CH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    LAST = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t state, state_nx;

  logic [15:0] ch_cnt, row_cnt, col_cnt;
  logic [31:0] op_cnt;
  logic [31:0] base;
  logic        col_wrap, row_wrap, last_word, start_ok;

  logic [31:0] word_a_p1, word_b_p1, word_c_p1, word_d_p1;
  logic [31:0] pooled;

  logic unused_rdata;
  assign unused_rdata = ^D_R_data;

  // Byte maximum; signed mode orders 8'h80 below 8'h7F.
  function automatic logic [7:0] max2(input logic [7:0] x, input logic [7:0] y);
    logic signed [7:0] xs;
    logic signed [7:0] ys;
    logic              gt;
    xs = x;
    ys = y;
    if (SIGNED != 0) gt = (xs > ys);
    else             gt = (x > y);
    return gt ? x : y;
  endfunction

  function automatic logic [7:0] max4(input logic [7:0] p, input logic [7:0] q,
                                      input logic [7:0] s, input logic [7:0] t);
    return max2(max2(p, q), max2(s, t));
  endfunction

  // Top-left source word of the current 2x2 window pair.
  assign base = 32'(SRC_BASE)
              + 32'(ch_cnt) * 32'(IMG_H * WPR)
              + 32'(row_cnt) * 32'(2 * WPR)
              + {15'b0, col_cnt, 1'b0};

  assign col_wrap  = (col_cnt == COL_LAST);
  assign row_wrap  = (row_cnt == ROW_LAST);
  assign last_word = col_wrap && row_wrap && (ch_cnt == CH_LAST);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RD0;
      RD0:        state_nx = RD1;
      RD1:        state_nx = RD2;
      RD2:        state_nx = RD3;
      RD3:        state_nx = LAST;
      LAST:       state_nx = WR;
      WR:         state_nx = last_word ? DONE : RD0;
      default:    state_nx = IDLE;
    endcase
  end

  // Position counters and finish flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      op_cnt  <= '0;
      finish  <= 1'b0;
    end else if (start_ok) begin
      ch_cnt  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      op_cnt  <= '0;
      finish  <= 1'b0;
    end else if (state == WR) begin
      op_cnt <= op_cnt + 32'd1;
      if (last_word) finish <= 1'b1;
      if (col_wrap) begin
        col_cnt <= '0;
        if (row_wrap) begin
          row_cnt <= '0;
          ch_cnt  <= ch_cnt + 16'd1;
        end else begin
          row_cnt <= row_cnt + 16'd1;
        end
      end else begin
        col_cnt <= col_cnt + 16'd1;
      end
    end
  end

  // Stage p1: capture the four source words, each one cycle after its request
  always_ff @(posedge clk) begin
    case (state)
      RD1:     word_a_p1 <= S_R_data;
      RD2:     word_b_p1 <= S_R_data;
      RD3:     word_c_p1 <= S_R_data;
      LAST:    word_d_p1 <= S_R_data;
      default: ;
    endcase
  end

  // Stage p2: pool A/C into the upper half-word and B/D into the lower one
  assign pooled = {
    max4(word_a_p1[31:24], word_a_p1[23:16], word_c_p1[31:24], word_c_p1[23:16]),
    max4(word_a_p1[15:8],  word_a_p1[7:0],   word_c_p1[15:8],  word_c_p1[7:0]),
    max4(word_b_p1[31:24], word_b_p1[23:16], word_d_p1[31:24], word_d_p1[23:16]),
    max4(word_b_p1[15:8],  word_b_p1[7:0],   word_d_p1[15:8],  word_d_p1[7:0])
  };

  assign S_W_req  = 4'b0000;
  assign S_W_data = 32'd0;
  assign D_R_req  = 1'b0;

  // Output logic
  always_comb begin
    S_R_req  = 1'b0;
    S_addr   = 32'd0;
    D_W_req  = 4'b0000;
    D_addr   = 32'd0;
    D_W_data = 32'd0;
    case (state)
      RD0: begin
        S_R_req = 1'b1;
        S_addr  = base;
      end
      RD1: begin
        S_R_req = 1'b1;
        S_addr  = base + 32'd1;
      end
      RD2: begin
        S_R_req = 1'b1;
        S_addr  = base + 32'(WPR);
      end
      RD3: begin
        S_R_req = 1'b1;
        S_addr  = base + 32'(WPR) + 32'd1;
      end
      WR: begin
        D_W_req  = 4'b1111;
        D_addr   = 32'(DST_BASE) + op_cnt;
        D_W_data = pooled;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maxpool2x2.sv
module tb_maxpool2x2;

  localparam int W       = 24;
  localparam int H       = 24;
  localparam int NC      = 4;
  localparam int WPR     = W / 4;
  localparam int OW      = W / 8;
  localparam int OH      = H / 2;
  localparam int NSRC    = NC * H * WPR;
  localparam int NOUT    = NC * OH * OW;
  localparam int FIN_CYC = 1 + 6 * NOUT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;

  logic        fin0, sreq0, drreq0, fin1, sreq1, drreq1;
  logic [31:0] saddr0, srd0, swd0, daddr0, dwd0;
  logic [31:0] saddr1, srd1, swd1, daddr1, dwd1;
  logic [3:0]  swreq0, dwreq0, swreq1, dwreq1;
  logic [31:0] drd = 32'h0;

  maxpool2x2 #(.IMG_W(W), .IMG_H(H), .CH(NC), .SRC_BASE(0), .DST_BASE(0), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst_n), .start(start), .finish(fin0),
    .S_R_req(sreq0), .S_addr(saddr0), .S_R_data(srd0), .S_W_req(swreq0), .S_W_data(swd0),
    .D_R_req(drreq0), .D_addr(daddr0), .D_R_data(drd), .D_W_req(dwreq0), .D_W_data(dwd0));

  maxpool2x2 #(.IMG_W(W), .IMG_H(H), .CH(NC), .SRC_BASE(0), .DST_BASE(0), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst_n), .start(start), .finish(fin1),
    .S_R_req(sreq1), .S_addr(saddr1), .S_R_data(srd1), .S_W_req(swreq1), .S_W_data(swd1),
    .D_R_req(drreq1), .D_addr(daddr1), .D_R_data(drd), .D_W_req(dwreq1), .D_W_data(dwd1));

  logic [31:0] src  [NSRC];
  logic [31:0] dst0 [NOUT];
  logic [31:0] dst1 [NOUT];
  logic [31:0] exp0 [NOUT];
  logic [31:0] exp1 [NOUT];

  int errors = 0;
  int checks = 0;
  int pcyc   = 0;
  int start_edge = 0;
  bit running = 1'b0;
  int idx0 = 0;
  int idx1 = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Source BRAM: one-cycle read latency, one port per DUT
  always @(posedge clk) begin
    if (sreq0) srd0 <= (saddr0 < NSRC) ? src[saddr0[9:0]] : 32'hDEADBEEF;
    if (sreq1) srd1 <= (saddr1 < NSRC) ? src[saddr1[9:0]] : 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (dwreq0 != 4'h0 && daddr0 < NOUT) dst0[daddr0[8:0]] <= dwd0;
    if (dwreq1 != 4'h0 && daddr1 < NOUT) dst1[daddr1[8:0]] <= dwd1;
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, pcyc - start_edge);
    end
  endtask

  // ---- behavioural model: 2x2 max over the pixel grid ----
  function automatic logic [7:0] pix(input int ch, input int y, input int x);
    logic [31:0] w;
    w = src[ch * H * WPR + y * WPR + x / 4];
    return w[31 - 8 * (x % 4) -: 8];
  endfunction

  function automatic int val(input bit sgn, input logic [7:0] b);
    if (sgn) return int'($signed(b));
    return int'(b);
  endfunction

  task automatic build_model();
    for (int op = 0; op < NOUT; op++) begin
      int ch, r, j;
      ch = op / (OH * OW);
      r  = (op / OW) % OH;
      j  = op % OW;
      for (int sgn = 0; sgn < 2; sgn++) begin
        logic [31:0] word;
        word = 32'h0;
        for (int k = 0; k < 4; k++) begin
          int p;
          logic [7:0] best;
          logic [7:0] cand;
          p = 4 * j + k;
          best = pix(ch, 2 * r, 2 * p);
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              cand = pix(ch, 2 * r + dy, 2 * p + dx);
              if (val(sgn[0], cand) > val(sgn[0], best)) best = cand;
            end
          word[31 - 8 * k -: 8] = best;
        end
        if (sgn == 0) exp0[op] = word;
        else          exp1[op] = word;
      end
    end
  endtask

  // ---- per-cycle write checker ----
  task automatic cmp_wr(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] expv, inout int idx);
    if (wen != 4'h0) begin
      if (!running || idx >= NOUT) begin
        check32({tag, "_stray_write"}, {28'h0, wen}, 32'h0);
      end else begin
        check32({tag, "_wen"},   {28'h0, wen}, 32'hF);
        check32({tag, "_waddr"}, addr, 32'(idx));
        check32({tag, "_wdata"}, data, expv);
        check32({tag, "_wtime"}, 32'(pcyc - start_edge), 32'(6 * (idx + 1)));
        idx++;
      end
    end
  endtask

  always @(negedge clk) begin
    cmp_wr("dut0", dwreq0, daddr0, dwd0, exp0[(idx0 < NOUT) ? idx0 : 0], idx0);
    cmp_wr("dut1", dwreq1, daddr1, dwd1, exp1[(idx1 < NOUT) ? idx1 : 0], idx1);
  end

  // ---- stimulus helpers ----
  task automatic start_run(input bit fin_before, input bit glitch);
    for (int i = 0; i < NOUT; i++) begin
      dst0[i] = 32'hA5A5A5A5;
      dst1[i] = 32'hA5A5A5A5;
    end
    @(posedge clk); #1;
    check32("fin_before0", {31'h0, fin0}, {31'h0, fin_before});
    check32("fin_before1", {31'h0, fin1}, {31'h0, fin_before});
    start = 1'b1;
    start_edge = pcyc;
    idx0 = 0;
    idx1 = 0;
    running = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check32("fin_drop0", {31'h0, fin0}, 32'h0);
    check32("fin_drop1", {31'h0, fin1}, 32'h0);
    if (glitch) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_run();
    int n, bad0, bad1;
    n = 0;
    while (!(fin0 || fin1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check32("fin_time", 32'(pcyc - start_edge), 32'(FIN_CYC));
    check32("fin_both", {30'h0, fin0, fin1}, 32'h3);
    repeat (3) @(negedge clk);
    check32("nwrites0", 32'(idx0), 32'(NOUT));
    check32("nwrites1", 32'(idx1), 32'(NOUT));
    check32("ties", {22'h0, swreq0, swreq1, drreq0, drreq1}, 32'h0);
    check32("ties_data", swd0 | swd1, 32'h0);
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < NOUT; i++) begin
      if (dst0[i] !== exp0[i]) bad0++;
      if (dst1[i] !== exp1[i]) bad1++;
    end
    check32("dst_mem0", 32'(bad0), 32'h0);
    check32("dst_mem1", 32'(bad1), 32'h0);
    running = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NSRC; i++) src[i] = $urandom;
  endtask

  initial begin
    int nz;
    rst_n = 1'b0;
    start = 1'b0;
    fill_random();
    build_model();
    repeat (3) @(negedge clk);
    check32("rst_outs0", {fin0, sreq0, dwreq0, 26'h0}, 32'h0);
    check32("rst_outs1", {fin1, sreq1, dwreq1, 26'h0}, 32'h0);
    check32("rst_addr", saddr0 | daddr0 | dwd0 | saddr1 | daddr1 | dwd1, 32'h0);
    rst_n = 1'b1;

    // Ramp: byte k = k mod 256
    for (int i = 0; i < NSRC; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      src[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
    end
    build_model();
    check32("pin_ramp", exp0[0], 32'h191B1D1F);
    start_run(1'b0, 1'b0);
    finish_run();

    // Random data, spurious start while in RD2, restart from DONE
    fill_random();
    build_model();
    start_run(1'b1, 1'b1);
    finish_run();

    // Single 0xFF at (row 1, col 7) of channel 2
    for (int i = 0; i < NSRC; i++) src[i] = 32'h0;
    src[2 * H * WPR + 1 * WPR + 1] = 32'h000000FF;
    build_model();
    nz = 0;
    for (int i = 0; i < NOUT; i++) if (exp0[i] != 32'h0) nz++;
    check32("pin_pos_word", exp0[72], 32'h000000FF);
    check32("pin_pos_count", 32'(nz), 32'd1);
    start_run(1'b1, 1'b0);
    finish_run();

    // Signed ordering: 0x7F beats 0x80 only when signed
    for (int i = 0; i < NSRC; i++) src[i] = 32'h80808080;
    src[0] = 32'h7F808080;
    build_model();
    check32("pin_signed", exp1[0], 32'h7F808080);
    check32("pin_unsigned", exp0[0], 32'h80808080);
    start_run(1'b1, 1'b0);
    finish_run();

    // Reset in cycle 100 of a run, then full rerun
    fill_random();
    build_model();
    start_run(1'b1, 1'b0);
    while (pcyc - start_edge < 99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    running = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("rst_mid_outs", {fin0, fin1, sreq0, sreq1, dwreq0, dwreq1, 20'h0}, 32'h0);
    end
    rst_n = 1'b1;
    start_run(1'b0, 1'b0);
    finish_run();

    // One more random run from DONE
    fill_random();
    build_model();
    start_run(1'b1, 1'b0);
    finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
